// File: rtl/shift_pkg.sv
// Shared constants and types for the iterative shift unit.
// Mode codes match the RV32I shift flavours seen by the execute stage.
package shift_pkg;

    localparam int SH_WIDTH   = 32;
    localparam int SH_SHAMT_W = 5;

    localparam logic [1:0] SH_SRL = 2'b00;
    localparam logic [1:0] SH_SRA = 2'b01;
    localparam logic [1:0] SH_SLL = 2'b10;
    localparam logic [1:0] SH_SLA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// One-bit shift step applied to the result register each SHIFT cycle.
// Mode 11 is an alias of left shift.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = SH_WIDTH
) (
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] d_o
);

    always_comb begin
        d_o = d_i;
        unique case (mode_i)
            SH_SRL:         d_o = {1'b0, d_i[WIDTH-1:1]};
            SH_SRA:         d_o = {d_i[WIDTH-1], d_i[WIDTH-1:1]};
            SH_SLL, SH_SLA: d_o = {d_i[WIDTH-2:0], 1'b0};
        endcase
    end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter: one bit per clock, result returned on valid/ready.
// All handshake outputs decode from registered state only.
module iter_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH   = SH_WIDTH,
    parameter int SHAMT_W = SH_SHAMT_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [1:0]         i_mode,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WIDTH-1:0]   o_result,
    output logic               o_busy
);

    shift_state_t       state_q, state_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   step_res;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode_i (mode_q),
        .d_i    (res_q),
        .d_o    (step_res)
    );

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    res_d  = i_a;
                    mode_d = i_mode;
                    cnt_d  = i_shamt;
                    state_d = (i_shamt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                res_d = step_res;
                cnt_d = cnt_q - SHAMT_W'(1);
                // Exit at one so the count never wraps below zero.
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign o_ready  = (state_q == ST_IDLE);
    assign o_valid  = (state_q == ST_DONE);
    assign o_busy   = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign o_result = res_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Bench for iter_shift_unit: directed scenarios plus random traffic
// checked against an arithmetic shift model.
module tb_iter_shift_unit;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_mode;
    logic [31:0] i_a;
    logic [4:0]  i_shamt;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_busy;

    int total = 0;
    int bad   = 0;

    iter_shift_unit dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_mode   (i_mode),
        .i_a      (i_a),
        .i_shamt  (i_shamt),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_busy   (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] m,
                                          input logic [31:0] a,
                                          input int s);
        logic signed [31:0] sa;
        sa = a;
        case (m)
            2'b00:   return a >> s;
            2'b01:   return 32'(sa >>> s);
            default: return a << s;
        endcase
    endfunction

    // Issue one request, wait for the result, accept it.
    // lat = edges after acceptance until o_valid (-1 on timeout).
    task automatic run_op(input logic [1:0] m, input logic [31:0] a,
                          input int s, output int lat,
                          output logic [31:0] res);
        int n;
        @(negedge clk);
        i_valid = 1'b1;
        i_mode  = m;
        i_a     = a;
        i_shamt = 5'(s);
        i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        i_a     = $urandom;
        i_mode  = 2'($urandom);
        i_shamt = 5'($urandom);
        n = 0;
        while (!o_valid && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        lat = o_valid ? n : -1;
        res = o_result;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_mode  = 2'b00;
        i_a     = '0;
        i_shamt = '0;
        #12;
        total++;
        if ({o_valid, o_busy, o_ready} !== 3'b001 || o_result !== 32'h0) begin
            bad++;
            $display("FAIL reset: v/b/r=%b res=%h want 001/00000000",
                     {o_valid, o_busy, o_ready}, o_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_dir(input string nm, input logic [1:0] m,
                            input logic [31:0] a, input int s,
                            input logic [31:0] want);
        int lat;
        logic [31:0] res;
        run_op(m, a, s, lat, res);
        total++;
        if (lat !== s) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", nm, lat, s);
        end
        total++;
        if (res !== want) begin
            bad++;
            $display("FAIL %s result: got %h want %h", nm, res, want);
        end
        total++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s ready after accept: got %b/%b want 1/0",
                     nm, o_ready, o_busy);
        end
    endtask

    task automatic test_srl;
        test_dir("srl4", 2'b00, 32'h8000_0000, 4, 32'h0800_0000);
    endtask

    task automatic test_sra;
        test_dir("sra31neg", 2'b01, 32'h8000_0000, 31, 32'hFFFF_FFFF);
        test_dir("sra31pos", 2'b01, 32'h7FFF_FFFF, 31, 32'h0000_0000);
    endtask

    task automatic test_sll;
        test_dir("sll31", 2'b10, 32'h0000_0001, 31, 32'h8000_0000);
        test_dir("sla31", 2'b11, 32'h0000_0001, 31, 32'h8000_0000);
    endtask

    task automatic test_shamt0;
        test_dir("shamt0", 2'b00, 32'h1234_5678, 0, 32'h1234_5678);
    endtask

    task automatic test_backpressure;
        int n;
        @(negedge clk);
        i_valid = 1'b1;
        i_mode  = 2'b10;
        i_a     = 32'h0000_00FF;
        i_shamt = 5'd8;
        i_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        n = 0;
        while (!o_valid && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        total++;
        if (n !== 8) begin
            bad++;
            $display("FAIL bp latency: got %0d want 8", n);
        end
        i_valid = 1'b1;
        i_mode  = 2'b00;
        i_a     = 32'hDEAD_BEEF;
        i_shamt = 5'd3;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (o_result !== 32'h0000_FF00 || o_ready !== 1'b0 ||
                o_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp hold%0d: res=%h rdy=%b v=%b want 0000ff00/0/1",
                         c, o_result, o_ready, o_valid);
            end
        end
        i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0 ||
            o_result !== 32'h0000_FF00) begin
            bad++;
            $display("FAIL bp release: rdy=%b busy=%b res=%h want 1/0/0000ff00",
                     o_ready, o_busy, o_result);
        end
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        n = 0;
        while (!o_valid && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        total++;
        if (n !== 3 || o_result !== model(2'b00, 32'hDEAD_BEEF, 3)) begin
            bad++;
            $display("FAIL bp next req: lat=%0d res=%h want 3/%h", n,
                     o_result, model(2'b00, 32'hDEAD_BEEF, 3));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        i_valid = 1'b1;
        i_mode  = 2'b00;
        i_a     = 32'hFFFF_FFFF;
        i_shamt = 5'd10;
        i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({o_valid, o_busy, o_ready} !== 3'b001 || o_result !== 32'h0) begin
            bad++;
            $display("FAIL rst mid: v/b/r=%b res=%h want 001/00000000",
                     {o_valid, o_busy, o_ready}, o_result);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_valid || o_busy) seen++;
        end
        total++;
        if (seen !== 0 || o_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst ghost: busy/valid cycles=%0d rdy=%b want 0/1",
                     seen, o_ready);
        end
    endtask

    task automatic test_random;
        int lat;
        int s;
        logic [1:0] m;
        logic [31:0] a;
        logic [31:0] res;
        logic [31:0] want;
        for (int k = 0; k < 40; k++) begin
            m = 2'($urandom);
            a = $urandom;
            s = $urandom_range(0, 31);
            want = model(m, a, s);
            run_op(m, a, s, lat, res);
            total++;
            if (lat !== s || res !== want) begin
                bad++;
                $display("FAIL rand%0d m=%0d a=%h s=%0d: lat=%0d res=%h want %0d/%h",
                         k, m, a, s, lat, res, s, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_srl();
        test_sra();
        test_sll();
        test_shamt0();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iter_shift_unit.md
Name: iter_shift_unit

Overview:
- Multi-cycle shift unit for the RV32I datapath, sequential counterpart to the combinational shifter.
- Takes one shift request per transaction and shifts one bit position per clock.
- Returns the result to the requester over a valid/ready handshake.
- Serves low-area configurations and multi-cycle execute stages, where the shift result can be consumed a variable number of cycles after issue.

Parameters:
- WIDTH, 32, data width in bits.
- SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W == WIDTH.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  request valid.
- o_ready  output  1  unit can accept a request (IDLE).
- i_mode  input  2  operation: 00 SRL, 01 SRA, 10 SLL, 11 SLL (same as 10).
- i_a  input  WIDTH  operand.
- i_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- o_valid  output  1  result valid (DONE).
- i_ready  input  1  requester accepts result.
- o_result  output  WIDTH  shifted result.
- o_busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (async, i_rst_n=0):
  - State goes to IDLE.
  - o_result=0, o_valid=0, o_busy=0, o_ready=1.
  - Internal count and latched mode go to 0.
  - Reset takes effect immediately, even mid-operation; the in-flight request is discarded and never reported.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - o_ready=1.
  - On an edge with i_valid=1, latch i_a into the result register, i_mode into the mode register and i_shamt into the count.
  - Go to SHIFT if i_shamt!=0; otherwise go straight to DONE.
- SHIFT:
  - Each edge applies one 1-bit step to the result register:
    - SRL: {0, r[W-1:1]}
    - SRA: {r[W-1], r[W-1:1]}
    - SLL: {r[W-2:0], 0}
  - Each edge also decrements the count.
  - When the count equals 1 at the edge, go to DONE.
  - i_valid is ignored (o_ready=0).
- DONE:
  - o_valid=1 and o_result is stable.
  - On an edge with i_ready=1, go to IDLE; o_result keeps its last value.
  - o_ready stays 0 throughout DONE, so no new request can be accepted in the same cycle as result acceptance.
- Latency: with the acceptance edge E0, o_valid is high after edge E0+shamt; shamt=0 gives o_valid in the cycle right after acceptance.
- Throughput: one request per shamt+2 cycles minimum, with i_ready held high.
- o_ready, o_valid and o_busy are decoded from registered state only; no combinational path from any input to any output.
- i_mode, i_a and i_shamt are sampled only at acceptance; later changes have no effect.
- Mode 11 behaves exactly as 10.
- Width rules:
  - The count is SHAMT_W bits and never underflows, because the SHIFT exit is at count==1.
  - SRA with shamt=WIDTH-1 yields all copies of the sign bit.
- Backpressure: DONE may last indefinitely while i_ready=0; o_result must not change.
- i_ready while not in DONE is ignored.

Decomposition:
- Shared package shift_pkg holds:
  - mode constants SH_SRL=2'b00, SH_SRA=2'b01, SH_SLL=2'b10, SH_SLA=2'b11;
  - state encoding ST_IDLE, ST_SHIFT, ST_DONE;
  - default WIDTH/SHAMT_W.
- One sub-module: shift_step, a combinational 1-bit step (mode, data in, data out), instanced once and feeding the result register.

Test Plan:
- SRL basic: i_a=0x8000_0000, i_shamt=4, i_mode=00, i_ready=1 -> o_valid after edge E0+4, o_result=0x0800_0000, then o_ready=1 next cycle.
- SRA sign fill: i_a=0x8000_0000, i_shamt=31, i_mode=01 -> o_result=0xFFFF_FFFF after 31 shift cycles; same with i_a=0x7FFF_FFFF -> 0x0000_0000.
- SLL and mode 11: i_a=0x0000_0001, i_shamt=31 under mode 10 and again under mode 11 -> o_result=0x8000_0000 in both cases.
- shamt=0: i_a=0x1234_5678, i_shamt=0 -> o_valid the cycle after acceptance, o_result=0x1234_5678.
- Backpressure plus ignored request:
  - Request SLL i_a=0x0000_00FF, i_shamt=8, then hold i_ready=0 for 3 cycles in DONE while driving i_valid=1 with new data.
  - Required: o_result stays 0x0000_FF00, o_ready=0, and the new request is not taken until after i_ready=1 is seen.
- Reset mid-operation:
  - Start SRL i_a=0xFFFF_FFFF, i_shamt=10; assert i_rst_n=0 after 2 shift cycles, between clock edges.
  - Required: o_valid=0, o_busy=0, o_ready=1, o_result=0 immediately, with no result reported after release.
